// File: rtl/chacha_block_sequencer.sv
// chacha_block_sequencer
//   Runs a complete ChaCha block function over a 16-word working state,
//   issuing one quarter-round per cycle to an external combinational QR unit.
//   Column rounds (qr_idx 0-3) and diagonal rounds (qr_idx 4-7) alternate;
//   an optional feed-forward pass then adds the start-time snapshot back in,
//   one word per cycle.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   wr_en/addr/data   bytewise state load (IDLE only), addr = {word, lane}
//   rd_addr/rd_data   combinational byte read of the working state
//   start, ff_en      launch a block (IDLE only); ff_en latched on launch
//   busy, done        busy during ROUND/FEED; done pulses one cycle at the end
//   qr_*_in/qr_*_out  operands to / results from the external QR unit
module chacha_block_sequencer #(
    parameter int unsigned ROUNDS = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [5:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic [5:0]  rd_addr,
    output logic [7:0]  rd_data,
    input  logic        start,
    input  logic        ff_en,
    output logic        busy,
    output logic        done,
    output logic [31:0] qr_a_in,
    output logic [31:0] qr_b_in,
    output logic [31:0] qr_c_in,
    output logic [31:0] qr_d_in,
    input  logic [31:0] qr_a_out,
    input  logic [31:0] qr_b_out,
    input  logic [31:0] qr_c_out,
    input  logic [31:0] qr_d_out
);

    localparam int unsigned RW = $clog2(ROUNDS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_FEED,
        S_DONE
    } state_e;

    state_e              fsm_q, fsm_d;
    logic [15:0][31:0]   state_q, state_d;
    logic [15:0][31:0]   snap_q, snap_d;
    logic [2:0]          qr_idx_q, qr_idx_d;
    logic [RW-1:0]       rnd_q, rnd_d;
    logic [3:0]          feed_q, feed_d;
    logic                ff_q, ff_d;

    // Quarter-round word selection. Every index has row r in its top two bits;
    // the column k is shared for column rounds and skewed by r for diagonals.
    logic                in_round;
    logic                diag;
    logic [1:0]          k0, k1, k2, k3;
    logic [3:0]          qi0, qi1, qi2, qi3;

    always_comb begin
        in_round = (fsm_q == S_ROUND);
        diag     = in_round && qr_idx_q[2];
        k0       = in_round ? qr_idx_q[1:0] : 2'd0;
        k1       = diag ? k0 + 2'd1 : k0;
        k2       = diag ? k0 + 2'd2 : k0;
        k3       = diag ? k0 + 2'd3 : k0;
        qi0      = {2'b00, k0};
        qi1      = {2'b01, k1};
        qi2      = {2'b10, k2};
        qi3      = {2'b11, k3};
    end

    assign qr_a_in = state_q[qi0];
    assign qr_b_in = state_q[qi1];
    assign qr_c_in = state_q[qi2];
    assign qr_d_in = state_q[qi3];

    assign rd_data = state_q[rd_addr[5:2]][{rd_addr[1:0], 3'b000} +: 8];

    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        snap_d   = snap_q;
        qr_idx_d = qr_idx_q;
        rnd_d    = rnd_q;
        feed_d   = feed_q;
        ff_d     = ff_q;
        busy     = 1'b0;
        done     = 1'b0;

        unique case (fsm_q)
            S_IDLE: begin
                if (start) begin
                    snap_d   = state_q;
                    ff_d     = ff_en;
                    qr_idx_d = '0;
                    rnd_d    = '0;
                    fsm_d    = S_ROUND;
                end else if (wr_en) begin
                    state_d[wr_addr[5:2]][{wr_addr[1:0], 3'b000} +: 8] = wr_data;
                end
            end

            S_ROUND: begin
                busy          = 1'b1;
                state_d[qi0]  = qr_a_out;
                state_d[qi1]  = qr_b_out;
                state_d[qi2]  = qr_c_out;
                state_d[qi3]  = qr_d_out;
                qr_idx_d      = qr_idx_q + 3'd1;
                // One full column+diagonal sweep is a double round.
                if (qr_idx_q == 3'd7) begin
                    rnd_d = rnd_q + RW'(2);
                    if (rnd_q == RW'(ROUNDS - 2)) begin
                        feed_d = '0;
                        fsm_d  = ff_q ? S_FEED : S_DONE;
                    end
                end
            end

            S_FEED: begin
                busy            = 1'b1;
                state_d[feed_q] = state_q[feed_q] + snap_q[feed_q];
                feed_d          = feed_q + 4'd1;
                if (feed_q == 4'd15) begin
                    fsm_d = S_DONE;
                end
            end

            S_DONE: begin
                done  = 1'b1;
                fsm_d = S_IDLE;
            end

            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q    <= S_IDLE;
            state_q  <= '0;
            snap_q   <= '0;
            qr_idx_q <= '0;
            rnd_q    <= '0;
            feed_q   <= '0;
            ff_q     <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            snap_q   <= snap_d;
            qr_idx_q <= qr_idx_d;
            rnd_q    <= rnd_d;
            feed_q   <= feed_d;
            ff_q     <= ff_d;
        end
    end

endmodule
